// File: rtl/rdm_combine_fsm_param_if.sv
// Control, input-buffer and soft-buffer signal bundle for rdm_combine_fsm_param.
// The engine connects through the slave modport; its environment uses master.
interface rdm_combine_fsm_param_if #(
    parameter int unsigned LLR_W         = 6,
    parameter int unsigned LLRS_PER_WORD = 16,
    parameter int unsigned ACC_W         = 8,
    parameter int unsigned E_W           = 14,
    parameter int unsigned NCB_W         = 16,
    parameter int unsigned ADDR_W        = 16
);
    logic                             i_Combine_process_request;
    logic [E_W-1:0]                   i_Current_Combine_E01_Size;
    logic [NCB_W-1:0]                 i_Current_Combine_Ncb_Size;
    logic [NCB_W-1:0]                 i_Current_Combine_K0;
    logic                             i_First_Tx;
    logic [ADDR_W-1:0]                i_Input_Buffer_Base;
    logic                             i_RDM_Data_Request;
    logic [ADDR_W-1:0]                o_Input_Buffer_Offset_Address;
    logic                             o_Input_Buffer_Rd_En;
    logic [LLR_W*LLRS_PER_WORD-1:0]   i_Input_Buffer_RDM_Data;
    logic                             o_Soft_Rd_En;
    logic [NCB_W-1:0]                 o_Soft_Rd_Addr;
    logic [ACC_W-1:0]                 i_Soft_Rd_Data;
    logic                             o_Soft_Wr_En;
    logic [NCB_W-1:0]                 o_Soft_Wr_Addr;
    logic [ACC_W-1:0]                 o_Soft_Wr_Data;
    logic                             o_Busy;
    logic                             o_Done;
    logic                             o_Cfg_Error;

    modport slave (
        input  i_Combine_process_request, i_Current_Combine_E01_Size,
        input  i_Current_Combine_Ncb_Size, i_Current_Combine_K0, i_First_Tx,
        input  i_Input_Buffer_Base, i_RDM_Data_Request,
        input  i_Input_Buffer_RDM_Data, i_Soft_Rd_Data,
        output o_Input_Buffer_Offset_Address, o_Input_Buffer_Rd_En,
        output o_Soft_Rd_En, o_Soft_Rd_Addr,
        output o_Soft_Wr_En, o_Soft_Wr_Addr, o_Soft_Wr_Data,
        output o_Busy, o_Done, o_Cfg_Error
    );

    modport master (
        output i_Combine_process_request, i_Current_Combine_E01_Size,
        output i_Current_Combine_Ncb_Size, i_Current_Combine_K0, i_First_Tx,
        output i_Input_Buffer_Base, i_RDM_Data_Request,
        output i_Input_Buffer_RDM_Data, i_Soft_Rd_Data,
        input  o_Input_Buffer_Offset_Address, o_Input_Buffer_Rd_En,
        input  o_Soft_Rd_En, o_Soft_Rd_Addr,
        input  o_Soft_Wr_En, o_Soft_Wr_Addr, o_Soft_Wr_Data,
        input  o_Busy, o_Done, o_Cfg_Error
    );
endinterface

// File: rtl/rdm_combine_fsm_param.sv
// Rate-dematching / HARQ soft-combine engine: streams E packed LLRs into an
// Ncb-entry circular soft buffer from k0, overwriting or saturating-accumulating.
module rdm_combine_fsm_param #(
    parameter int unsigned LLR_W         = 6,
    parameter int unsigned LLRS_PER_WORD = 16,
    parameter int unsigned ACC_W         = 8,
    parameter int unsigned E_W           = 14,
    parameter int unsigned NCB_W         = 16,
    parameter int unsigned ADDR_W        = 16
) (
    input  logic                  i_core_clk,
    input  logic                  i_rx_rst,
    rdm_combine_fsm_param_if.slave bus
);
    localparam int unsigned J_W = (LLRS_PER_WORD > 1) ? $clog2(LLRS_PER_WORD) : 1;
    localparam int unsigned S_W = ACC_W + 1;
    localparam logic [J_W-1:0] J_LAST = J_W'(LLRS_PER_WORD - 1);
    localparam logic signed [S_W-1:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [S_W-1:0] SUM_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_COMBINE, S_DRAIN, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [E_W-1:0]                 e_q, n_q;
    logic [NCB_W-1:0]               ncb_q, p_q, wr_addr_q;
    logic                           first_tx_q, wr_en_q, cfg_err_q;
    logic [ADDR_W-1:0]              base_q, word_idx_q;
    logic [LLR_W*LLRS_PER_WORD-1:0] word_q;
    logic [J_W-1:0]                 j_q;
    logic [LLR_W-1:0]               llr_q;

    logic                           cfg_ok, start, bad_cfg, issue, n_last, j_last;
    logic [LLR_W-1:0]               llr_arr [LLRS_PER_WORD];
    logic [LLR_W-1:0]               llr_cur;
    logic [NCB_W-1:0]               p_inc, p_next;
    logic signed [S_W-1:0]          sum;
    logic [ACC_W-1:0]               wr_data;

    assign cfg_ok = (bus.i_Current_Combine_E01_Size != '0)
                 && (bus.i_Current_Combine_Ncb_Size >= NCB_W'(2))
                 && (bus.i_Current_Combine_K0 < bus.i_Current_Combine_Ncb_Size);
    assign n_last = ((n_q + E_W'(1)) == e_q);
    assign j_last = (j_q == J_LAST);
    assign p_inc  = p_q + NCB_W'(1);
    assign p_next = (p_inc == ncb_q) ? '0 : p_inc;

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        bad_cfg = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_Combine_process_request) begin
                    if (cfg_ok) begin
                        start   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        bad_cfg = 1'b1;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_COMBINE;
            S_COMBINE: begin
                if (bus.i_RDM_Data_Request) begin
                    issue = 1'b1;
                    // The E-th LLR ends the job even mid-word; leftover LLRs are dropped.
                    if (n_last) begin
                        state_d = S_DRAIN;
                    end else if (j_last) begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // LLR 0 sits in the most significant slot of the input word.
    always_comb begin
        for (int unsigned k = 0; k < LLRS_PER_WORD; k++) begin
            llr_arr[k] = word_q[(LLRS_PER_WORD-1-k)*LLR_W +: LLR_W];
        end
    end
    assign llr_cur = llr_arr[j_q];

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            e_q        <= '0;
            ncb_q      <= '0;
            first_tx_q <= 1'b0;
            base_q     <= '0;
            word_idx_q <= '0;
            word_q     <= '0;
            j_q        <= '0;
            n_q        <= '0;
            p_q        <= '0;
            llr_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            wr_en_q   <= issue;
            cfg_err_q <= bad_cfg;
            if (state_q == S_IDLE && bus.i_Combine_process_request) begin
                e_q        <= bus.i_Current_Combine_E01_Size;
                ncb_q      <= bus.i_Current_Combine_Ncb_Size;
                first_tx_q <= bus.i_First_Tx;
                base_q     <= bus.i_Input_Buffer_Base;
            end
            if (start) begin
                p_q        <= bus.i_Current_Combine_K0;
                n_q        <= '0;
                word_idx_q <= '0;
            end
            if (state_q == S_FETCH) begin
                word_idx_q <= word_idx_q + ADDR_W'(1);
            end
            if (state_q == S_WAIT) begin
                word_q <= bus.i_Input_Buffer_RDM_Data;
                j_q    <= '0;
            end
            if (issue) begin
                llr_q     <= llr_cur;
                wr_addr_q <= p_q;
                j_q       <= j_q + J_W'(1);
                n_q       <= n_q + E_W'(1);
                p_q       <= p_next;
            end
        end
    end

    // Symmetric clamp: the most negative code is never written back.
    always_comb begin
        sum = {{(S_W-LLR_W){llr_q[LLR_W-1]}}, llr_q};
        if (!first_tx_q) begin
            sum = sum + {bus.i_Soft_Rd_Data[ACC_W-1], bus.i_Soft_Rd_Data};
        end
        if (sum > SUM_MAX) begin
            wr_data = SUM_MAX[ACC_W-1:0];
        end else if (sum < SUM_MIN) begin
            wr_data = SUM_MIN[ACC_W-1:0];
        end else begin
            wr_data = sum[ACC_W-1:0];
        end
    end

    assign bus.o_Input_Buffer_Rd_En          = (state_q == S_FETCH);
    assign bus.o_Input_Buffer_Offset_Address = (state_q == S_FETCH) ? (base_q + word_idx_q) : '0;
    assign bus.o_Soft_Rd_En                  = issue & ~first_tx_q;
    assign bus.o_Soft_Rd_Addr                = (issue & ~first_tx_q) ? p_q : '0;
    assign bus.o_Soft_Wr_En                  = wr_en_q;
    assign bus.o_Soft_Wr_Addr                = wr_en_q ? wr_addr_q : '0;
    assign bus.o_Soft_Wr_Data                = wr_en_q ? wr_data : '0;
    assign bus.o_Busy                        = (state_q != S_IDLE);
    assign bus.o_Done                        = (state_q == S_DONE);
    assign bus.o_Cfg_Error                   = cfg_err_q;
endmodule
